// File: rtl/full_adder.sv
// 1-bit full adder with zero-latency combinational sum/carry and a registered copy.
// Optional FULL_ADDER_CNT_EN adds a saturating 8-bit count of cycles with carry set.
module full_adder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  output logic       out,
  output logic       carry,
  output logic       sum_q,
  output logic       carry_q
`ifdef FULL_ADDER_CNT_EN
  ,
  output logic [7:0] carry_cnt
`endif
);

  logic sum_d;
  logic carry_d;

  // NOTE: combinational outputs get a full assignment on every path, so no latch is inferred.
  always_comb begin
    out   = in0 ^ in1 ^ in2;
    carry = (in0 & in1) | (in0 & in2) | (in1 & in2);
  end

  assign sum_d   = out;
  assign carry_d = carry;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

`ifdef FULL_ADDER_CNT_EN
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Saturates at 8'hFF rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (carry && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: expected values are queued when stimulus is
// driven and popped when the output is sampled. Define FULL_ADDER_CNT_EN to cover the counter.
module tb_full_adder;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_entry_t;

  logic clk;
  logic rst_n;
  logic in0;
  logic in1;
  logic in2;
  logic out;
  logic carry;
  logic sum_q;
  logic carry_q;
`ifdef FULL_ADDER_CNT_EN
  logic [7:0] carry_cnt;
`endif

  sb_entry_t sb[$];
  int checks = 0;
  int errors = 0;

  full_adder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .out      (out),
    .carry    (carry),
    .sum_q    (sum_q),
    .carry_q  (carry_q)
`ifdef FULL_ADDER_CNT_EN
    ,
    .carry_cnt(carry_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not terminate");
  end

  task automatic push(input string tag, input logic [7:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [7:0] observed);
    sb_entry_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, observed, e.exp);
      end
    end
  endtask

  task automatic drive(input logic [2:0] v);
    {in2, in1, in0} = v;
  endtask

  initial begin
    logic [7:0] out_tab;
    logic [7:0] carry_tab;
    out_tab   = 8'b1001_0110;  // out   for {in2,in1,in0} = 7..0
    carry_tab = 8'b1110_1000;  // carry for {in2,in1,in0} = 7..0

    rst_n = 1'b0;
    drive(3'b000);
    #1;
    push("reset_sum_q", 8'd0);   check({7'd0, sum_q});
    push("reset_carry_q", 8'd0); check({7'd0, carry_q});

    // Exhaustive combinational sweep, held in reset to show independence from rst_n.
    for (int v = 0; v < 8; v++) begin
      drive(3'(v));
      push($sformatf("comb_out_%0d", v), {7'd0, out_tab[v]});
      push($sformatf("comb_carry_%0d", v), {7'd0, carry_tab[v]});
      #1;
      check({7'd0, out});
      check({7'd0, carry});
      #1;
    end
    push("reset_hold_sum_q", 8'd0); check({7'd0, sum_q});

    // Registered path: 011 then 111.
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b011);
    push("reg_k_sum_q", 8'd0);
    push("reg_k_carry_q", 8'd1);
    @(posedge clk); #1;
    check({7'd0, sum_q});
    check({7'd0, carry_q});
    drive(3'b111);
    push("reg_k1_sum_q", 8'd1);
    push("reg_k1_carry_q", 8'd1);
    @(posedge clk); #1;
    check({7'd0, sum_q});
    check({7'd0, carry_q});

    // Asynchronous reset between edges while sum_q=1.
    #2;
    rst_n = 1'b0;
    push("async_sum_q", 8'd0);
    push("async_carry_q", 8'd0);
    push("async_out", 8'd1);
    #1;
    check({7'd0, sum_q});
    check({7'd0, carry_q});
    check({7'd0, out});
    drive(3'b010);
    push("reset_track_out", 8'd1);
    push("reset_track_carry", 8'd0);
    #1;
    check({7'd0, out});
    check({7'd0, carry});

    // Reset release: first capture only on the next rising edge.
    @(negedge clk);
    drive(3'b001);
    rst_n = 1'b1;
    push("release_pre_sum_q", 8'd0);
    #1;
    check({7'd0, sum_q});
    push("release_post_sum_q", 8'd1);
    push("release_post_carry_q", 8'd0);
    @(posedge clk); #1;
    check({7'd0, sum_q});
    check({7'd0, carry_q});

    // Input change between edges moves only the combinational outputs.
    drive(3'b000);
    push("midcycle_out", 8'd0);
    push("midcycle_sum_q", 8'd1);
    #1;
    check({7'd0, out});
    check({7'd0, sum_q});

`ifdef FULL_ADDER_CNT_EN
    rst_n = 1'b0;
    push("cnt_reset", 8'h00);
    #1;
    check(carry_cnt);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b111);
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (i == 254) begin
        push("cnt_254", 8'hFE); check(carry_cnt);
      end else if (i == 255) begin
        push("cnt_255", 8'hFF); check(carry_cnt);
      end
    end
    push("cnt_saturated", 8'hFF); check(carry_cnt);
    rst_n = 1'b0;
    push("cnt_async_clear", 8'h00);
    #1;
    check(carry_cnt);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 3'b011 : 3'b001);
      @(posedge clk); #1;
    end
    push("cnt_alternate", 8'd5); check(carry_cnt);
`endif

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
